ark_run_ctrl: RTL
=================

Name: ark_run_ctrl

Overview:
Run controller for the ARK core. It owns the Start/Ack handshake and the program counter, and gates core write enables (register file, data memory) so state changes only while a program is running. It sits directly under TopLevel: TopLevel's Reset/Start/Ack ports connect straight through, and the core supplies halt and branch requests. It also counts executed cycles and aborts runaway programs on a timeout.

Parameters:
PC_W, 10, program counter width; the PC wraps modulo 2**PC_W.
OFF_W, 8, width of the signed relative-branch offset.
CYC_W, 16, cycle counter width.
MAX_CYCLES, 16'hFFFF, run-cycle limit that triggers timeout; 0 disables the limit.

Ports:
Clk  input  1  system clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset.
Start  input  1  level request; high = arm and hold, falling edge launches the program.
Halt  input  1  decoded halt instruction from the core, valid during RUN.
BranchAbs  input  1  absolute jump request.
BranchRel  input  1  relative branch taken.
Target  input  PC_W  absolute jump target.
Offset  input  OFF_W  signed relative offset, two's complement.
PC  output  PC_W  current instruction address.
CoreEn  output  1  write-enable gate for RF and DM; high only in RUN.
Ack  output  1  done flag, registered.
TimedOut  output  1  high with Ack when the run ended by timeout.
CycleCount  output  CYC_W  RUN cycles executed in the current or last run.

Behaviour:
- Reset (synchronous, highest priority, legal in any state including mid-run):
  - state=IDLE, PC=0, Ack=0, CoreEn=0, TimedOut=0, CycleCount=0.
- States: IDLE, ARMED, RUN, DONE. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE: Ack=0, CoreEn=0.
  - Start=1 -> ARMED.
- ARMED: PC forced to 0, CycleCount and TimedOut cleared, CoreEn=0, Ack=0.
  - Start=0 -> RUN on the next edge; the first RUN cycle fetches PC=0.
- RUN: CoreEn=1. Each edge, in priority order:
  1. Start=1 aborts: -> ARMED, PC to 0.
  2. Halt=1: -> DONE, PC holds the halt address.
  3. Timeout: MAX_CYCLES!=0 and CycleCount==MAX_CYCLES-1 -> DONE with TimedOut=1, PC holds.
  4. BranchAbs=1: PC<=Target.
  5. BranchRel=1: PC<=PC+sign_extend(Offset), truncated to PC_W.
  6. Otherwise PC<=PC+1, mod 2**PC_W.
- Simultaneous requests: BranchAbs wins over BranchRel; Halt wins over both; a Halt in the same cycle as the timeout gives TimedOut=0.
- CycleCount increments by 1 every RUN cycle, including the halt cycle, and saturates at all-ones.
- DONE: Ack=1, CoreEn=0; PC and CycleCount frozen.
  - Start=1 -> ARMED; Ack falls on that edge.
  - Branch and Halt inputs are ignored.
- Latency:
  - Halt sampled at edge k: Ack=1 and CoreEn=0 are visible after edge k.
  - The halt instruction's own writes (cycle before edge k) are enabled; no writes occur afterwards.
- Wrap:
  - PC = 2**PC_W-1 with no branch wraps to 0.
  - A relative branch below 0 wraps modulo 2**PC_W.

Decomposition:
- Package ark_ctrl_pkg holds:
  - the state enum run_state_t {IDLE, ARMED, RUN, DONE};
  - default PC_W/OFF_W constants, shared with the instruction ROM and branch decode.
- One sub-module, ark_pc_next: combinational next-PC select (hold, +1, absolute, relative with sign extension), parameterised on PC_W/OFF_W.
- The FSM and counters stay in ark_run_ctrl.

Test Plan:
- Reset=1 for 1 cycle, then Start=1 for 1 cycle, then Start=0, no branches -> PC sequence 0,1,2,...; CoreEn=1 from the first RUN cycle; Ack=0.
- Halt at PC=5 -> Ack=1 and CoreEn=0 the next cycle, PC stays 5, CycleCount=6, TimedOut=0.
- At PC=3: BranchRel with Offset=8'hFE -> PC=1. At PC=1: BranchAbs with Target=10'h200 and BranchRel asserted together -> PC=10'h200. At PC=10'h3FF with no branch -> PC=0.
- MAX_CYCLES=20, program never halts -> Ack=1 and TimedOut=1 after 20 RUN cycles, CycleCount=20; with Halt on cycle 20 instead -> TimedOut=0.
- Start=1 mid-RUN at PC=7 -> next cycle state ARMED, PC=0, CoreEn=0. After Start=0 the run restarts from 0 with CycleCount cleared.
- Reset=1 mid-RUN at PC=9 -> all outputs 0 the next cycle. From DONE, Start=1 -> Ack drops on the next edge and the second run completes normally.

Source files
------------

// File: rtl/ark_ctrl_pkg.sv
// Shared definitions for the ARK run controller, instruction ROM and branch decode.
package ark_ctrl_pkg;

    // Default widths shared across the ARK core
    localparam int PC_W_DEF  = 10;
    localparam int OFF_W_DEF = 8;
    localparam int CYC_W_DEF = 16;

    // Run controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } run_state_t;

    // Next-PC source select
    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_ABS  = 2'd2,
        PC_REL  = 2'd3
    } pc_sel_t;

endpackage

// File: rtl/ark_pc_next.sv
// Combinational next-PC select: hold, increment, absolute jump or signed relative branch.
module ark_pc_next
    import ark_ctrl_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int OFF_W = OFF_W_DEF
) (
    input  pc_sel_t           sel,
    input  logic [PC_W-1:0]   pc,
    input  logic [PC_W-1:0]   target,
    input  logic [OFF_W-1:0]  offset,
    output logic [PC_W-1:0]   pc_next
);

    logic [PC_W-1:0] offset_ext;

    // Sign-extend (or truncate) the offset to PC width; the sum then wraps naturally
    generate
        if (PC_W > OFF_W) begin : g_ext
            assign offset_ext = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
        end else begin : g_trunc
            assign offset_ext = offset[PC_W-1:0];
        end
    endgenerate

    // Select the next program counter value
    always_comb begin
        pc_next = pc;
        case (sel)
            PC_HOLD: pc_next = pc;
            PC_INC:  pc_next = pc + 1'b1;
            PC_ABS:  pc_next = target;
            PC_REL:  pc_next = pc + offset_ext;
            default: pc_next = pc;
        endcase
    end

endmodule

// File: rtl/ark_run_ctrl.sv
// ARK run controller: Start/Ack handshake, program counter, write-enable gating,
// run-cycle counting and timeout abort.
module ark_run_ctrl
    import ark_ctrl_pkg::*;
#(
    parameter int               PC_W       = PC_W_DEF,
    parameter int               OFF_W      = OFF_W_DEF,
    parameter int               CYC_W      = CYC_W_DEF,
    parameter logic [CYC_W-1:0] MAX_CYCLES = 16'hFFFF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Halt,
    input  logic              BranchAbs,
    input  logic              BranchRel,
    input  logic [PC_W-1:0]   Target,
    input  logic [OFF_W-1:0]  Offset,
    output logic [PC_W-1:0]   PC,
    output logic              CoreEn,
    output logic              Ack,
    output logic              TimedOut,
    output logic [CYC_W-1:0]  CycleCount
);

    localparam bit               TIMEOUT_EN = (MAX_CYCLES != '0);
    localparam logic [CYC_W-1:0] LAST_CYCLE = MAX_CYCLES - 1'b1;

    run_state_t       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d, pc_next;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             to_q, to_d;
    logic             timeout_hit;
    pc_sel_t          pc_sel;

    assign timeout_hit = TIMEOUT_EN && (cyc_q == LAST_CYCLE);

    // State and datapath registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cyc_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cyc_q   <= cyc_d;
            to_q    <= to_d;
        end
    end

    // Next-state logic; in RUN an abort beats halt, which beats timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = ARMED;
            ARMED:   if (!Start) state_d = RUN;
            RUN: begin
                if (Start)            state_d = ARMED;
                else if (Halt)        state_d = DONE;
                else if (timeout_hit) state_d = DONE;
            end
            DONE:    if (Start) state_d = ARMED;
            default: state_d = IDLE;
        endcase
    end

    // PC source: only a RUN cycle that stays in RUN advances the PC
    always_comb begin
        pc_sel = PC_HOLD;
        if (state_q == RUN && state_d == RUN) begin
            if (BranchAbs)      pc_sel = PC_ABS;
            else if (BranchRel) pc_sel = PC_REL;
            else                pc_sel = PC_INC;
        end
    end

    ark_pc_next #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_pc_next (
        .sel     (pc_sel),
        .pc      (pc_q),
        .target  (Target),
        .offset  (Offset),
        .pc_next (pc_next)
    );

    // Counter, timeout flag and PC updates; entering or sitting in ARMED clears them
    always_comb begin
        pc_d  = pc_next;
        cyc_d = cyc_q;
        to_d  = to_q;
        if (state_d == ARMED) begin
            pc_d  = '0;
            cyc_d = '0;
            to_d  = 1'b0;
        end else if (state_q == RUN) begin
            cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;
            // Reaching DONE without Halt means the timeout ended the run
            if (state_d == DONE) to_d = !Halt;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        PC         = pc_q;
        CycleCount = cyc_q;
        TimedOut   = to_q;
        CoreEn     = (state_q == RUN);
        Ack        = (state_q == DONE);
    end

endmodule
